// File: rtl/data_mem_dump_ctrl.sv
// rtl/data_mem_dump_ctrl.sv - debug sequencer dumping data memory words as LSB-first bytes
module data_mem_dump_ctrl #(
  parameter int NB_DEPTH = 8,
  parameter int NB_DATA  = 32,
  parameter int NB_BYTE  = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_mem_debug_enb,
  output logic [NB_DEPTH-3:0] o_mem_addr,
  input  logic [NB_DATA-1:0]  i_mem_data,
  output logic [NB_BYTE-1:0]  o_tx_data,
  output logic                o_tx_valid,
  input  logic                i_tx_ready
);

  localparam int NB_ADDR = NB_DEPTH - 2;
  localparam logic [NB_ADDR-1:0] ADDR_LAST = '1;
  localparam logic [NB_ADDR-1:0] ADDR_ONE  = NB_ADDR'(1);
  localparam logic [1:0]         BYTE_LAST = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_SEND,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [NB_ADDR-1:0]   addr_q, addr_d;
  logic [1:0]           byte_cnt_q, byte_cnt_d;
  logic [NB_DATA-1:0]   word_q, word_d;
  logic [NB_BYTE-1:0]   tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [1:0]           byte_cnt_nxt;

  // State and datapath registers; reset also aborts a dump in flight and drops the pending byte
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Next-state logic: read a word, capture it, stream its four bytes, advance until the last word
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    byte_cnt_nxt = byte_cnt_q + 2'd1;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          addr_d  = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        word_d     = i_mem_data;
        byte_cnt_d = '0;
        tx_data_d  = i_mem_data[NB_BYTE-1:0];
        tx_valid_d = 1'b1;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (tx_valid_q && i_tx_ready) begin
          if (byte_cnt_q != BYTE_LAST) begin
            byte_cnt_d = byte_cnt_nxt;
            tx_data_d  = word_q[int'(byte_cnt_nxt) * NB_BYTE +: NB_BYTE];
          end else begin
            tx_valid_d = 1'b0;
            if (addr_q == ADDR_LAST) begin
              state_d = S_DONE;
            end else begin
              addr_d  = addr_q + ADDR_ONE;
              state_d = S_READ;
            end
          end
        end
      end
      S_DONE: begin
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Memory returns to pipeline access whenever no word is being read or streamed
  always_comb begin
    o_busy          = (state_q != S_IDLE);
    o_done          = (state_q == S_DONE);
    o_mem_debug_enb = (state_q == S_IDLE) || (state_q == S_DONE);
    o_mem_addr      = addr_q;
    o_tx_data       = tx_data_q;
    o_tx_valid      = tx_valid_q;
  end

endmodule

// File: tb/tb_data_mem_dump_ctrl.sv
// tb/tb_data_mem_dump_ctrl.sv - directed bench for data_mem_dump_ctrl
module tb_data_mem_dump_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        dbg_enb;
  logic [5:0]  mem_addr;
  logic [31:0] mem_data = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  logic [31:0] mem [64];
  logic [7:0]  rx_q [$];
  int          done_cnt = 0;
  int          dbg_viol = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  data_mem_dump_ctrl #(.NB_DEPTH(8), .NB_DATA(32), .NB_BYTE(8)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start),
    .o_busy          (busy),
    .o_done          (done),
    .o_mem_debug_enb (dbg_enb),
    .o_mem_addr      (mem_addr),
    .i_mem_data      (mem_data),
    .o_tx_data       (tx_data),
    .o_tx_valid      (tx_valid),
    .i_tx_ready      (tx_ready)
  );

  always #5 clk = ~clk;

  // Registered debug read port of the data memory
  always @(posedge clk) begin
    if (!dbg_enb) mem_data <= mem[mem_addr];
  end

  // Byte sink, done counter and debug-enable watcher
  always @(negedge clk) begin
    if (tx_valid && tx_ready && !rst) rx_q.push_back(tx_data);
    if (done) done_cnt++;
    if (busy && !done && dbg_enb) dbg_viol++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (!done && cyc < 2000) begin
      tick();
      cyc++;
    end
    check_eq({tag, "_done_seen"}, {31'd0, done}, 32'd1);
  endtask

  function automatic logic [7:0] exp_byte(input int idx);
    logic [31:0] w;
    w = mem[(idx >> 2) & 63];
    return w[(idx % 4) * 8 +: 8];
  endfunction

  task automatic check_stream(input string tag, input int nbytes);
    int errs = 0;
    check_eq({tag, "_count"}, rx_q.size(), nbytes);
    for (int i = 0; i < rx_q.size() && i < nbytes; i++)
      if (rx_q[i] !== exp_byte(i)) errs++;
    check_eq({tag, "_data"}, errs, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int cyc;
    logic [7:0] hold_data;
    logic [5:0] hold_addr;
    int chg;

    for (int i = 0; i < 64; i++) mem[i] = {i[7:0] ^ 8'h5A, i[7:0], 8'hC3, ~i[7:0]};
    mem[0] = 32'h11223344;
    mem[1] = 32'hAABBCCDD;
    rst = 1'b1;
    start = 1'b0;
    tx_ready = 1'b1;
    do_reset();

    // reset state
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_dbg_enb", {31'd0, dbg_enb}, 32'd1);
    check_eq("rst_addr", {26'd0, mem_addr}, 32'd0);
    check_eq("rst_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("rst_data", {24'd0, tx_data}, 32'd0);

    // full dump, ready tied high
    rx_q.delete(); done_cnt = 0; dbg_viol = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 2000) begin
      tick();
      cyc++;
    end
    check_eq("t1_latency", cyc, 385);
    check_eq("t6_last_addr", {26'd0, mem_addr}, 32'd63);
    tick();
    check_eq("t6_addr_zero", {26'd0, mem_addr}, 32'd0);
    check_eq("t6_dbg_enb_back", {31'd0, dbg_enb}, 32'd1);
    check_eq("t1_busy_idle", {31'd0, busy}, 32'd0);
    repeat (5) tick();
    check_eq("t1_b0", {24'd0, rx_q[0]}, 32'h44);
    check_eq("t1_b1", {24'd0, rx_q[1]}, 32'h33);
    check_eq("t1_b2", {24'd0, rx_q[2]}, 32'h22);
    check_eq("t1_b3", {24'd0, rx_q[3]}, 32'h11);
    check_eq("t1_b4", {24'd0, rx_q[4]}, 32'hDD);
    check_eq("t1_b5", {24'd0, rx_q[5]}, 32'hCC);
    check_eq("t1_b6", {24'd0, rx_q[6]}, 32'hBB);
    check_eq("t1_b7", {24'd0, rx_q[7]}, 32'hAA);
    check_stream("t1", 256);
    check_eq("t1_done_cnt", done_cnt, 1);
    check_eq("t6_dbg_viol", dbg_viol, 0);

    // backpressure for 10 cycles in word 5, byte 2
    rx_q.delete(); done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!(rx_q.size() == 22 && tx_valid) && cyc < 1000) begin
      tick();
      cyc++;
    end
    check_eq("t2_reach", rx_q.size(), 22);
    tx_ready = 1'b0;
    hold_data = tx_data;
    hold_addr = mem_addr;
    check_eq("t2_hold_byte", {24'd0, hold_data}, {24'd0, mem[5][23:16]});
    check_eq("t2_hold_addr", {26'd0, hold_addr}, 32'd5);
    chg = 0;
    repeat (10) begin
      tick();
      if (!tx_valid || tx_data !== hold_data || mem_addr !== hold_addr) chg++;
    end
    check_eq("t2_stable", chg, 0);
    tx_ready = 1'b1;
    wait_done("t2", cyc);
    repeat (5) tick();
    check_stream("t2", 256);
    check_eq("t2_done_cnt", done_cnt, 1);

    // start pulse while busy is ignored
    rx_q.delete(); done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (50) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t3", cyc);
    repeat (20) tick();
    check_stream("t3", 256);
    check_eq("t3_done_cnt", done_cnt, 1);
    check_eq("t3_busy", {31'd0, busy}, 32'd0);

    // start held high: back-to-back dumps
    rx_q.delete(); done_cnt = 0;
    start = 1'b1;
    wait_done("t4a", cyc);
    tick();
    check_eq("t4_idle_gap", {31'd0, busy}, 32'd0);
    tick();
    check_eq("t4_restart", {31'd0, busy}, 32'd1);
    wait_done("t4b", cyc);
    start = 1'b0;
    repeat (10) tick();
    check_eq("t4_count", rx_q.size(), 512);
    check_eq("t4_done_cnt", done_cnt, 2);
    check_eq("t4_busy", {31'd0, busy}, 32'd0);

    // reset at word 10, byte 2
    rx_q.delete(); done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!(rx_q.size() == 42 && tx_valid) && cyc < 1000) begin
      tick();
      cyc++;
    end
    check_eq("t5_reach", {26'd0, mem_addr}, 32'd10);
    rst = 1'b1;
    tick();
    check_eq("t5_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("t5_busy", {31'd0, busy}, 32'd0);
    check_eq("t5_dbg_enb", {31'd0, dbg_enb}, 32'd1);
    check_eq("t5_addr", {26'd0, mem_addr}, 32'd0);
    check_eq("t5_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    tick();
    check_eq("t5_no_done", done_cnt, 0);
    rx_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t5", cyc);
    repeat (5) tick();
    check_stream("t5", 256);
    check_eq("t5_done_cnt", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
